// File: rtl/lu_serial_driver_pkg.sv
// Shared types and constants for the logicalunit serial driver.
// Func codes are logicalunit truth tables indexed by {a,b}.
package lu_serial_driver_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam logic [3:0] FUNC_AND = 4'b1000;
    localparam logic [3:0] FUNC_OR  = 4'b1110;
    localparam logic [3:0] FUNC_XOR = 4'b0110;
    localparam logic [3:0] FUNC_NOR = 4'b0001;

endpackage

// File: rtl/lu_serial_driver.sv
// Serialises two WIDTH-bit operands LSB first into an external combinational
// logicalunit and gathers its output bits into a result vector.
module lu_serial_driver
    import lu_serial_driver_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [3:0]       cmd_func,
    input  logic [WIDTH-1:0] cmd_a,
    input  logic [WIDTH-1:0] cmd_b,
    output logic             lu_a,
    output logic             lu_b,
    output logic [3:0]       lu_func,
    input  logic             lu_out,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_data,
    output logic             busy
);

    localparam int IDX_W = $clog2(WIDTH);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WIDTH - 1);

    state_t           state, state_nx;
    logic [IDX_W-1:0] idx;
    logic [WIDTH-1:0] a_sh, b_sh, res_sh;
    logic             accept, last;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx  = state;
        cmd_ready = 1'b0;
        accept    = 1'b0;
        last      = 1'b0;
        case (state)
            IDLE: begin
                cmd_ready = !rst;
                if (cmd_valid && !rst) begin
                    accept   = 1'b1;
                    state_nx = RUN;
                end
            end
            RUN: begin
                if (idx == IDX_LAST) begin
                    last     = 1'b1;
                    state_nx = HOLD;
                end
            end
            HOLD: begin
                if (res_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    assign res_valid = (state == HOLD);
    assign busy      = (state != IDLE);

    // lu_a/lu_b are registered one bit ahead of the shift regs so the bit
    // presented to logicalunit is always the one captured at the next edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx      <= '0;
            a_sh     <= '0;
            b_sh     <= '0;
            res_sh   <= '0;
            res_data <= '0;
            lu_a     <= 1'b0;
            lu_b     <= 1'b0;
            lu_func  <= 4'b0000;
        end else if (accept) begin
            a_sh    <= cmd_a;
            b_sh    <= cmd_b;
            lu_func <= cmd_func;
            idx     <= '0;
            lu_a    <= cmd_a[0];
            lu_b    <= cmd_b[0];
        end else if (state == RUN) begin
            res_sh <= {lu_out, res_sh[WIDTH-1:1]};
            a_sh   <= a_sh >> 1;
            b_sh   <= b_sh >> 1;
            if (last) begin
                res_data <= {lu_out, res_sh[WIDTH-1:1]};
                lu_a     <= 1'b0;
                lu_b     <= 1'b0;
            end else begin
                idx  <= idx + 1'b1;
                lu_a <= a_sh[1];
                lu_b <= b_sh[1];
            end
        end
    end

endmodule

// File: tb/tb_lu_serial_driver.sv
// Bench: driver plus a behavioural logicalunit, scoreboard-checked against a
// per-bit truth-table model of the result.
module tb_lu_serial_driver;
    import lu_serial_driver_pkg::*;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         cmd_valid, cmd_ready;
    logic [3:0]   cmd_func;
    logic [W-1:0] cmd_a, cmd_b;
    logic         lu_a, lu_b, lu_out;
    logic [3:0]   lu_func;
    logic         res_valid, res_ready, busy;
    logic [W-1:0] res_data;

    lu_serial_driver #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_func(cmd_func),
        .cmd_a(cmd_a), .cmd_b(cmd_b),
        .lu_a(lu_a), .lu_b(lu_b), .lu_func(lu_func), .lu_out(lu_out),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .busy(busy)
    );

    // logicalunit: out = func[{a,b}]
    assign lu_out = lu_func[{lu_a, lu_b}];

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] res;
        logic [3:0]   func;
        int           acc;
    } exp_t;

    exp_t exp_q[$];
    int   cyc = 0;
    int   n_chk = 0, n_fail = 0;
    logic chk_spacing = 1'b0, timeout_hit = 1'b0, done = 1'b0, rand_rdy = 1'b0;

    function automatic logic [W-1:0] model(input logic [3:0] f, input logic [W-1:0] a,
                                           input logic [W-1:0] b);
        logic [W-1:0] r;
        for (int i = 0; i < W; i++) r[i] = f[{a[i], b[i]}];
        return r;
    endfunction

    always @(posedge clk) cyc++;

    // Monitor: signals are stable at negedge; the next active edge is cyc+1.
    logic         held = 1'b0, have_last = 1'b0, to_seen = 1'b0, done_seen = 1'b0;
    logic [W-1:0] held_data = '0;
    int           last_acc = 0;
    always @(negedge clk) begin
        if (rst) begin
            n_chk++;
            if (cmd_ready || res_valid || busy || lu_a || lu_b || lu_func != 4'b0 || res_data != '0) begin
                n_fail++;
                $display("FAIL reset_outputs: rdy=%b vld=%b busy=%b a=%b b=%b func=%h data=%h, all required 0",
                         cmd_ready, res_valid, busy, lu_a, lu_b, lu_func, res_data);
            end
            exp_q.delete();
            held = 1'b0;
            have_last = 1'b0;
        end else begin
            n_chk++;
            if (cmd_ready && res_valid) begin
                n_fail++;
                $display("FAIL ready_valid_excl: cmd_ready=1 and res_valid=1 at cycle %0d", cyc);
            end
            n_chk++;
            if (busy !== !cmd_ready) begin
                n_fail++;
                $display("FAIL busy_vs_ready: busy=%b cmd_ready=%b, required opposite", busy, cmd_ready);
            end
            if (cmd_valid && cmd_ready) begin
                exp_q.push_back('{model(cmd_func, cmd_a, cmd_b), cmd_func, cyc + 1});
                if (chk_spacing && have_last) begin
                    n_chk++;
                    if (cyc + 1 - last_acc != W + 2) begin
                        n_fail++;
                        $display("FAIL accept_spacing: %0d cycles, required %0d", cyc + 1 - last_acc, W + 2);
                    end
                end
                last_acc = cyc + 1;
                have_last = 1'b1;
            end
            if (res_valid) begin
                n_chk++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL spurious_result: res_valid with data %h, no command outstanding", res_data);
                end else begin
                    if (!held && (cyc + 1 - exp_q[0].acc != W + 1)) begin
                        n_fail++;
                        $display("FAIL latency: %0d cycles, required %0d", cyc + 1 - exp_q[0].acc, W + 1);
                    end
                    n_chk++;
                    if (lu_a || lu_b || lu_func != exp_q[0].func) begin
                        n_fail++;
                        $display("FAIL hold_lu_outputs: a=%b b=%b func=%h, required 0 0 %h",
                                 lu_a, lu_b, lu_func, exp_q[0].func);
                    end
                end
                if (held) begin
                    n_chk++;
                    if (res_data != held_data) begin
                        n_fail++;
                        $display("FAIL hold_stable: data %h, required %h", res_data, held_data);
                    end
                end
                if (res_ready) begin
                    if (exp_q.size() != 0) begin
                        n_chk++;
                        if (res_data != exp_q[0].res) begin
                            n_fail++;
                            $display("FAIL result: func=%h got %h, required %h", exp_q[0].func, res_data, exp_q[0].res);
                        end
                        void'(exp_q.pop_front());
                    end
                    held = 1'b0;
                end else begin
                    held = 1'b1;
                    held_data = res_data;
                end
            end else begin
                held = 1'b0;
            end
        end
        if (timeout_hit && !to_seen) begin
            n_chk++;
            n_fail++;
            to_seen = 1'b1;
            $display("FAIL timeout: handshake not seen within cycle budget at cycle %0d", cyc);
        end
        if (done && !done_seen) begin
            n_chk++;
            done_seen = 1'b1;
            if (exp_q.size() != 0) begin
                n_fail++;
                $display("FAIL leftover: %0d results outstanding, required 0", exp_q.size());
            end
        end
    end

    task automatic wait_accept();
        logic acc = 1'b0;
        for (int t = 0; t < 200 && !acc; t++) begin
            @(negedge clk);
            acc = cmd_ready;
            @(posedge clk);
            #1;
            if (rand_rdy) res_ready = 1'($urandom_range(0, 1));
        end
        if (!acc) timeout_hit = 1'b1;
        cmd_valid = 1'b0;
        cmd_func  = 4'($urandom);
        cmd_a     = W'($urandom);
        cmd_b     = W'($urandom);
    endtask

    task automatic send(input logic [3:0] f, input logic [W-1:0] a, input logic [W-1:0] b);
        cmd_valid = 1'b1;
        cmd_func  = f;
        cmd_a     = a;
        cmd_b     = b;
        wait_accept();
    endtask

    task automatic drain();
        for (int t = 0; t < 200; t++) begin
            if (exp_q.size() == 0 && !res_valid && !busy) return;
            @(posedge clk);
            #1;
            res_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
        end
        timeout_hit = 1'b1;
    endtask

    initial begin
        rst = 1'b1; cmd_valid = 1'b0; cmd_func = '0; cmd_a = '0; cmd_b = '0; res_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        send(FUNC_AND, 8'hF0, 8'hCC); drain();
        send(FUNC_OR,  8'hF0, 8'hCC); drain();
        send(FUNC_XOR, 8'hF0, 8'hCC); drain();
        send(FUNC_NOR, 8'h00, 8'h00); drain();
        send(FUNC_NOR, 8'hFF, 8'hFF); drain();

        // result held with consumer stalled while a new command waits
        res_ready = 1'b0;
        send(FUNC_AND, 8'hA5, 8'h3C);
        cmd_valid = 1'b1; cmd_func = FUNC_XOR; cmd_a = 8'h5A; cmd_b = 8'hFF;
        for (int t = 0; t < 50 && !res_valid; t++) begin
            @(posedge clk);
            #1;
        end
        repeat (5) @(posedge clk);
        #1 res_ready = 1'b1;
        wait_accept();
        drain();

        // reset three cycles into RUN discards the partial result
        send(FUNC_OR, 8'h0F, 8'h33);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        send(FUNC_AND, 8'hF0, 8'hCC); drain();

        // back-to-back with the consumer always ready
        send(FUNC_AND, 8'hF0, 8'hCC);
        chk_spacing = 1'b1;
        send(FUNC_XOR, 8'h96, 8'h0F);
        chk_spacing = 1'b0;
        drain();

        rand_rdy = 1'b1;
        for (int n = 0; n < 25; n++) send(4'($urandom), W'($urandom), W'($urandom));
        rand_rdy = 1'b0;
        drain();

        done = 1'b1;
        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
